// File: rtl/dds_sweep_ctrl.sv
// Register-write master for DDS_Top: writes amplitude once, then sweeps the frequency word.
// Build option DDS_SWEEP_TRIANGLE_EN turns the sawtooth sweep into an up/down triangle sweep.
module dds_sweep_ctrl #(
    parameter logic [15:0] FREQ_ADDR = 16'h0020,
    parameter logic [15:0] AMP_ADDR  = 16'h0030,
    parameter int          DW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          continuous,
    input  logic [DW-1:0] cfg_amp,
    input  logic [DW-1:0] f_start,
    input  logic [DW-1:0] f_stop,
    input  logic [DW-1:0] f_step,
    input  logic [15:0]   dwell,
    output logic          wr,
    output logic [15:0]   waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done
);

    // state     | meaning
    // S_IDLE    | waiting for start, cfg sampled here
    // S_AMP_WR  | amplitude register write on the bus
    // S_GAP     | one quiet cycle before the first frequency write
    // S_FREQ_WR | frequency register write on the bus
    // S_DWELL   | hold current frequency, down-counter running
    // S_DONE    | single-shot sweep finished, done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_AMP_WR, S_GAP, S_FREQ_WR, S_DWELL, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   cur_q, cur_d;
    logic [DW-1:0]   fstart_q, fstop_q, step_q;
    logic [15:0]     dwell_q, cnt_q, cnt_d;
    logic            cont_q;
    logic            load;
    logic [DW:0]     up_sum;
    logic [DW-1:0]   up_nxt;

    logic            wr_q, wr_d;
    logic [15:0]     waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

`ifdef DDS_SWEEP_TRIANGLE_EN
    logic            dir_q, dir_d;
    logic [DW:0]     dn_diff, rs_sum;
    logic [DW-1:0]   dn_nxt, rs_nxt;
`endif

    // Carry out of the DW+1-bit sum always compares above f_stop.
    assign up_sum = {1'b0, cur_q} + {1'b0, step_q};
    assign up_nxt = (up_sum > {1'b0, fstop_q}) ? fstop_q : up_sum[DW-1:0];

`ifdef DDS_SWEEP_TRIANGLE_EN
    assign dn_diff = {1'b0, cur_q} - {1'b0, step_q};
    assign dn_nxt  = (dn_diff[DW] || (dn_diff[DW-1:0] < fstart_q)) ? fstart_q : dn_diff[DW-1:0];
    assign rs_sum  = {1'b0, fstart_q} + {1'b0, step_q};
    assign rs_nxt  = (rs_sum > {1'b0, fstop_q}) ? fstop_q : rs_sum[DW-1:0];
`endif

    assign load = (state_q == S_IDLE) && start && !abort;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
`ifdef DDS_SWEEP_TRIANGLE_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_AMP_WR;
                    cur_d   = f_start;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    dir_d   = 1'b0;
`endif
                end
            end
            S_AMP_WR: state_d = S_GAP;
            S_GAP:    state_d = S_FREQ_WR;
            S_FREQ_WR: begin
                state_d = S_DWELL;
                cnt_d   = dwell_q - 16'd1;
            end
            S_DWELL: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    state_d = S_FREQ_WR;
`ifdef DDS_SWEEP_TRIANGLE_EN
                    if (!dir_q && (cur_q < fstop_q)) begin
                        cur_d = up_nxt;
                    end else if (cur_q > fstart_q) begin
                        dir_d = 1'b1;
                        cur_d = dn_nxt;
                    end else if (cont_q) begin
                        dir_d = 1'b0;
                        cur_d = (fstart_q < fstop_q) ? rs_nxt : fstart_q;
                    end else begin
                        state_d = S_DONE;
                    end
`else
                    if (cur_q < fstop_q) begin
                        cur_d = up_nxt;
                    end else if (cont_q) begin
                        cur_d = fstart_q;
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are registered decodes of the next state, so they line up with the state itself.
    always_comb begin
        wr_d    = 1'b0;
        waddr_d = 16'd0;
        wdata_d = '0;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        if (state_d == S_AMP_WR) begin
            wr_d    = 1'b1;
            waddr_d = AMP_ADDR;
            wdata_d = cfg_amp;
        end else if (state_d == S_FREQ_WR) begin
            wr_d    = 1'b1;
            waddr_d = FREQ_ADDR;
            wdata_d = cur_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            cnt_q    <= 16'd0;
            fstart_q <= '0;
            fstop_q  <= '0;
            step_q   <= '0;
            dwell_q  <= 16'd0;
            cont_q   <= 1'b0;
            wr_q     <= 1'b0;
            waddr_q  <= 16'd0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            if (load) begin
                fstart_q <= f_start;
                fstop_q  <= f_stop;
                step_q   <= (f_step == '0) ? {{(DW-1){1'b0}}, 1'b1} : f_step;
                dwell_q  <= (dwell == 16'd0) ? 16'd1 : dwell;
                cont_q   <= continuous;
            end
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DDS_SWEEP_TRIANGLE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign wr    = wr_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
